// File: rtl/fetch_ctrl.sv
// Instruction fetch sequencer: owns the PC, buffers {pc, instr} in a prefetch FIFO, flushes on redirect.
// Optional build macro FETCH_PERF_CNT_EN adds saturating fetched/flushed performance counters.
module fetch_ctrl #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        fetch_en,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ready,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    output logic        busy
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_flushed
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);

    logic [31:0]   pc_q, pc_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [31:0]   instr_q [DEPTH];
    logic [31:0]   pcs_q   [DEPTH];
    logic          push, pop;

    assign imem_addr = pc_q;
    assign out_valid = (count_q != '0);
    assign out_instr = out_valid ? instr_q[rd_ptr_q] : 32'h0;
    assign out_pc    = out_valid ? pcs_q[rd_ptr_q]   : 32'h0;
    assign busy      = out_valid | (fetch_en & ~redirect_valid);

    // Redirect overrides both push and pop; a full FIFO may still push when it pops in the same cycle.
    always_comb begin
        pop      = out_valid & out_ready;
        push     = fetch_en & imem_ready & ~redirect_valid & ((count_q < DEPTH_C) | pop);
        pc_d     = pc_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (redirect_valid) begin
            pc_d     = redirect_pc & 32'hFFFF_FFFC;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                pc_d     = pc_q + 32'd4;
                wr_ptr_d = wr_ptr_q + PTR_ONE;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
            end
            if (push && !pop) begin
                count_d = count_q + CNT_ONE;
            end else if (pop && !push) begin
                count_d = count_q - CNT_ONE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q     <= RESET_PC;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            pc_q     <= pc_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // When full, the write slot equals the head being popped this cycle, so overwriting it is safe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                instr_q[i] <= 32'h0;
                pcs_q[i]   <= 32'h0;
            end
        end else if (push) begin
            instr_q[wr_ptr_q] <= imem_rdata;
            pcs_q[wr_ptr_q]   <= pc_q;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetched_q, perf_flushed_q;
    logic [32:0] flushed_sum;

    assign flushed_sum  = {1'b0, perf_flushed_q} + 33'(count_q);
    assign perf_fetched = perf_fetched_q;
    assign perf_flushed = perf_flushed_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_fetched_q <= 32'h0;
            perf_flushed_q <= 32'h0;
        end else begin
            if (push && (perf_fetched_q != 32'hFFFF_FFFF)) begin
                perf_fetched_q <= perf_fetched_q + 32'd1;
            end
            if (redirect_valid) begin
                perf_flushed_q <= flushed_sum[32] ? 32'hFFFF_FFFF : flushed_sum[31:0];
            end
        end
    end
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: directed scenarios plus randomized traffic against a queue model.
module tb_fetch_ctrl;
    localparam int          DEPTH = 4;
    localparam logic [31:0] RPC   = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        fetch_en = 1'b0;
    logic        imem_ready = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        out_ready = 1'b0;
    logic [31:0] imem_addr, imem_rdata, out_instr, out_pc;
    logic        out_valid, busy;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetched, perf_flushed;
`endif

    int errors = 0;
    int checks = 0;

    logic [31:0] m_pc;
    logic [31:0] q_pc[$];
    logic [31:0] q_in[$];
    logic [31:0] m_fetched, m_flushed;

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_f(input logic [31:0] a);
        if (a == 32'h0) return 32'h0000_00B3;
        if (a == 32'h4) return 32'h0000_00A3;
        return (a * 32'h9E37_79B9) ^ 32'h1357_2468;
    endfunction

    assign imem_rdata = mem_f(imem_addr);

    fetch_ctrl #(.DEPTH(DEPTH), .RESET_PC(RPC)) dut (
        .clk(clk), .rst_n(rst_n), .fetch_en(fetch_en), .imem_addr(imem_addr),
        .imem_rdata(imem_rdata), .imem_ready(imem_ready), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .out_valid(out_valid), .out_ready(out_ready),
        .out_instr(out_instr), .out_pc(out_pc), .busy(busy)
`ifdef FETCH_PERF_CNT_EN
        , .perf_fetched(perf_fetched), .perf_flushed(perf_flushed)
`endif
    );

    task automatic model_clear();
        m_pc = RPC;
        q_pc.delete();
        q_in.delete();
        m_fetched = 0;
        m_flushed = 0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        fetch_en = 1'b0; imem_ready = 1'b0; redirect_valid = 1'b0;
        redirect_pc = 32'h0; out_ready = 1'b0;
        model_clear();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Drive one cycle of inputs, advance the queue model, return at the following falling edge.
    task automatic step(input logic fe, input logic ir, input logic rv,
                        input logic [31:0] rpc, input logic ordy);
        bit do_pop, do_push;
        fetch_en = fe; imem_ready = ir; redirect_valid = rv;
        redirect_pc = rpc; out_ready = ordy;
        do_pop  = (q_pc.size() != 0) && ordy;
        do_push = fe && ir && !rv && ((q_pc.size() < DEPTH) || do_pop);
        if (rv) begin
            m_flushed = m_flushed + q_pc.size();
            q_pc.delete();
            q_in.delete();
            m_pc = {rpc[31:2], 2'b00};
        end else begin
            if (do_pop) begin
                void'(q_pc.pop_front());
                void'(q_in.pop_front());
            end
            if (do_push) begin
                q_pc.push_back(m_pc);
                q_in.push_back(mem_f(m_pc));
                m_pc = m_pc + 32'd4;
                m_fetched = m_fetched + 1;
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        fetch_en = 1'b0;
        #3;
        checks++;
        if (out_valid !== 1'b0 || out_instr !== 32'h0 || out_pc !== 32'h0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: valid=%b instr=%h pc=%h busy=%b, want 0/0/0/0",
                     out_valid, out_instr, out_pc, busy);
        end
        checks++;
        if (imem_addr !== RPC) begin
            errors++;
            $display("FAIL reset_addr: got %h want %h", imem_addr, RPC);
        end
        do_reset();
    endtask

    task automatic test_basic();
        do_reset();
        step(1, 1, 0, 32'h0, 1);
        checks++;
        if (out_valid !== 1'b1 || out_pc !== 32'h0 || out_instr !== 32'h0000_00B3 || imem_addr !== 32'h4) begin
            errors++;
            $display("FAIL basic_c1: valid=%b pc=%h instr=%h addr=%h, want 1/0/000000b3/4",
                     out_valid, out_pc, out_instr, imem_addr);
        end
        step(1, 1, 0, 32'h0, 1);
        checks++;
        if (out_valid !== 1'b1 || out_pc !== 32'h4 || out_instr !== 32'h0000_00A3 || imem_addr !== 32'h8) begin
            errors++;
            $display("FAIL basic_c2: valid=%b pc=%h instr=%h addr=%h, want 1/4/000000a3/8",
                     out_valid, out_pc, out_instr, imem_addr);
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        repeat (5) step(1, 1, 0, 32'h0, 0);
        checks++;
        if (imem_addr !== 32'h10 || out_valid !== 1'b1 || out_pc !== 32'h0) begin
            errors++;
            $display("FAIL bp_full: addr=%h valid=%b pc=%h, want 10/1/0", imem_addr, out_valid, out_pc);
        end
        for (int k = 1; k <= 4; k++) begin
            step(1, 1, 0, 32'h0, 1);
            checks++;
            if (out_valid !== 1'b1 || out_pc !== 32'(4 * k) || imem_addr !== 32'(16 + 4 * k)) begin
                errors++;
                $display("FAIL bp_drain%0d: valid=%b pc=%h addr=%h, want 1/%h/%h",
                         k, out_valid, out_pc, imem_addr, 32'(4 * k), 32'(16 + 4 * k));
            end
        end
    endtask

    task automatic test_redirect();
        do_reset();
        repeat (3) step(1, 1, 0, 32'h0, 0);
        step(1, 1, 1, 32'h103, 1);
        checks++;
        if (out_valid !== 1'b0 || imem_addr !== 32'h100) begin
            errors++;
            $display("FAIL redir_flush: valid=%b addr=%h, want 0/100", out_valid, imem_addr);
        end
`ifdef FETCH_PERF_CNT_EN
        checks++;
        if (perf_flushed !== 32'd3) begin
            errors++;
            $display("FAIL redir_perf: flushed=%0d want 3", perf_flushed);
        end
`endif
        step(1, 1, 0, 32'h0, 1);
        checks++;
        if (out_valid !== 1'b1 || out_pc !== 32'h100 || out_instr !== mem_f(32'h100)) begin
            errors++;
            $display("FAIL redir_first: valid=%b pc=%h instr=%h, want 1/100/%h",
                     out_valid, out_pc, out_instr, mem_f(32'h100));
        end
    endtask

    task automatic test_imem_wait();
        logic [31:0] exp_addr [4];
        logic        rdy [4];
        exp_addr = '{32'h4, 32'h4, 32'h4, 32'h8};
        rdy = '{1'b1, 1'b0, 1'b0, 1'b1};
        do_reset();
        for (int i = 0; i < 4; i++) begin
            step(1, rdy[i], 0, 32'h0, 0);
            checks++;
            if (imem_addr !== exp_addr[i]) begin
                errors++;
                $display("FAIL wait_addr%0d: got %h want %h", i, imem_addr, exp_addr[i]);
            end
        end
        checks++;
        if (out_pc !== 32'h0) begin
            errors++;
            $display("FAIL wait_head0: got %h want 0", out_pc);
        end
        step(0, 1, 0, 32'h0, 1);
        checks++;
        if (out_valid !== 1'b1 || out_pc !== 32'h4) begin
            errors++;
            $display("FAIL wait_head1: valid=%b pc=%h want 1/4", out_valid, out_pc);
        end
        step(0, 1, 0, 32'h0, 1);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL wait_empty: valid=%b want 0", out_valid);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        step(1, 1, 1, 32'hFFFF_FFFE, 0);
        step(1, 1, 0, 32'h0, 1);
        checks++;
        if (out_pc !== 32'hFFFF_FFFC || imem_addr !== 32'h0) begin
            errors++;
            $display("FAIL wrap_a: pc=%h addr=%h want fffffffc/0", out_pc, imem_addr);
        end
        step(1, 1, 0, 32'h0, 1);
        checks++;
        if (out_pc !== 32'h0 || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL wrap_b: pc=%h valid=%b want 0/1", out_pc, out_valid);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        repeat (2) step(1, 1, 0, 32'h0, 0);
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || imem_addr !== RPC || out_pc !== 32'h0) begin
            errors++;
            $display("FAIL async_rst: valid=%b addr=%h pc=%h want 0/%h/0", out_valid, imem_addr, out_pc, RPC);
        end
        do_reset();
    endtask

    task automatic test_random();
        logic [31:0] exp_pc, exp_in;
        do_reset();
        for (int i = 0; i < 600; i++) begin
            step(($urandom % 8) != 0, ($urandom % 4) != 0, ($urandom % 16) == 0,
                 $urandom, ($urandom % 3) != 0);
            exp_pc = (q_pc.size() != 0) ? q_pc[0] : 32'h0;
            exp_in = (q_in.size() != 0) ? q_in[0] : 32'h0;
            checks++;
            if (out_valid !== (q_pc.size() != 0) || out_pc !== exp_pc || out_instr !== exp_in) begin
                errors++;
                $display("FAIL rand_head%0d: valid=%b pc=%h instr=%h want %b/%h/%h",
                         i, out_valid, out_pc, out_instr, q_pc.size() != 0, exp_pc, exp_in);
            end
            checks++;
            if (imem_addr !== m_pc || busy !== ((q_pc.size() != 0) || (fetch_en && !redirect_valid))) begin
                errors++;
                $display("FAIL rand_pc%0d: addr=%h busy=%b want %h/%b", i, imem_addr, busy, m_pc,
                         (q_pc.size() != 0) || (fetch_en && !redirect_valid));
            end
        end
`ifdef FETCH_PERF_CNT_EN
        checks++;
        if (perf_fetched !== m_fetched || perf_flushed !== m_flushed) begin
            errors++;
            $display("FAIL rand_perf: fetched=%0d flushed=%0d want %0d/%0d",
                     perf_fetched, perf_flushed, m_fetched, m_flushed);
        end
`endif
    endtask

    initial begin
        model_clear();
        test_reset();
        test_basic();
        test_backpressure();
        test_redirect();
        test_imem_wait();
        test_wrap();
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
Instruction fetch sequencer sitting between the instruction memory and the decode stage. Owns the program counter and drives the word address into the combinational instruction memory. Buffers fetched words with their PCs in a small prefetch FIFO and presents them to decode over a valid/ready handshake. Handles branch/jump redirects by flushing the FIFO and restarting fetch.

Parameters:
DEPTH, 4, prefetch FIFO entries; power of two, 2..16
RESET_PC, 32'h0000_0000, PC loaded on reset; bits [1:0] must be 0

Ports:
clk  input  1  single clock, rising edge
rst_n  input  1  asynchronous active-low reset
fetch_en  input  1  1 = fetch allowed; 0 = no new pushes, FIFO still drains
imem_addr  output  32  byte address to instruction memory, always equal to pc
imem_rdata  input  32  instruction word, combinational from imem_addr, same cycle
imem_ready  input  1  1 = imem_rdata valid this cycle; 0 = memory wait, hold pc
redirect_valid  input  1  1-cycle pulse: flush and refetch from redirect_pc
redirect_pc  input  32  redirect target; bits [1:0] ignored (forced 0)
out_valid  output  1  head entry available to decode
out_ready  input  1  decode accepts head entry
out_instr  output  32  instruction at FIFO head
out_pc  output  32  PC of instruction at FIFO head
busy  output  1  1 when FIFO is non-empty or a fetch is being attempted this cycle

Behaviour:
- Reset (async assert, sync release): pc=RESET_PC, FIFO empty, count=0, rd/wr ptrs 0. out_valid=0, out_instr=0, out_pc=0, busy=0.
- Outputs come straight from FIFO head registers. out_valid = (count != 0). Head data is 0 when empty.
- pop = out_valid & out_ready.
- push = fetch_en & imem_ready & !redirect_valid & (count < DEPTH | pop).
  - Push writes {pc, imem_rdata}; pc <= pc + 4 (32-bit wrap: 0xFFFF_FFFC -> 0x0000_0000).
- Simultaneous push and pop: count unchanged; allowed when full.
- Latency: a word fetched in cycle N is visible on out_valid/out_instr in cycle N+1. Steady state is 1 instr/cycle when out_ready=1 and imem_ready=1.
- imem_ready=0: no push; pc and imem_addr hold. Pops continue.
- fetch_en=0: no push; pc holds. Pops continue.
- redirect_valid=1 has priority over push and pop:
  - FIFO flushed (count=0, ptrs reset).
  - pc <= {redirect_pc[31:2], 2'b00}.
  - No push that cycle; any pop that cycle is discarded.
  - out_valid=0 in cycle N+1; first redirected instruction valid in N+2 at the earliest.
- Back-to-back redirects: the last one wins.
- count width = $clog2(DEPTH)+1. Pointers wrap modulo DEPTH.
- busy = (count != 0) | (fetch_en & !redirect_valid).
- Reset asserted mid-operation: all state returns to reset values immediately. In-flight FIFO contents are lost.

Optional Feature:
FETCH_PERF_CNT_EN
- Defined: adds output perf_fetched[31:0], counting pushes, and output perf_flushed[31:0], counting valid entries discarded by redirects (adds count at the redirect cycle). Both reset to 0, saturate at 0xFFFF_FFFF, no effect on the datapath.
- Not defined: both ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset release, fetch_en=1, imem_ready=1, out_ready=1, mem returns 0x000000B3 at 0x0 and 0x000000A3 at 0x4 -> cycle1 out_pc=0x0 out_instr=0x000000B3, cycle2 out_pc=0x4 out_instr=0x000000A3, pc increments by 4 each cycle.
- out_ready=0 with DEPTH=4 -> after 4 pushes count=4, imem_addr holds 0x10. Then out_ready=1 -> entries 0x0,0x4,0x8,0xC come out in order with no gap, and fetching resumes the same cycle.
- redirect_valid pulse with redirect_pc=0x103 while FIFO holds 3 entries -> next cycle out_valid=0 and imem_addr=0x100. Following cycle out_pc=0x100. With FETCH_PERF_CNT_EN, perf_flushed=3.
- imem_ready toggling 1,0,0,1 -> only 2 pushes occur and imem_addr holds across the wait cycles. No duplicate or skipped PCs.
- Redirect to 0xFFFF_FFFC -> out_pc sequence is 0xFFFF_FFFC then 0x0000_0000.
- rst_n asserted low mid-stream with FIFO at 2 entries -> out_valid=0 and imem_addr=RESET_PC asynchronously, before the next clk edge.
